// File: rtl/apb_reg_slave.sv
// APB3 completer register bank: NUM_REGS word registers with programmable wait
// states, PSLVERR on bad addresses and a sticky protocol-violation flag.
module apb_reg_slave #(
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter int unsigned               NUM_REGS       = 16,
  parameter int unsigned               WAIT_STATES    = 0,
  parameter logic [APB_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                               apbClk,
  input  logic                               rst,
  input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
  input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
  input  logic                               PSEL,
  input  logic                               PENABLE,
  input  logic                               PWRITE,
  output logic [APB_DATA_WIDTH-1:0]          PRDATA,
  output logic                               PREADY,
  output logic                               PSLVERR,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_o,
  output logic                               proto_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned DW    = APB_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic                proto_err_q, proto_err_d;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];

  logic [IDX_W-1:0]          addr_idx;
  logic [APB_ADDR_WIDTH-1:0] word_addr;
  logic                      addr_err;
  logic                      access;

  assign addr_idx  = PADDR[IDX_W+1:2];
  assign word_addr = PADDR >> 2;
  assign addr_err  = (PADDR[1:0] != 2'b00) || (word_addr >= APB_ADDR_WIDTH'(NUM_REGS));
  assign access    = PSEL && PENABLE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    prdata_d    = prdata_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    proto_err_d = proto_err_q;
    regs_d      = regs_q;

    unique case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = addr_idx;
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = addr_err;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            // Zero wait states: respond straight from the live setup-phase decode.
            state_d   = S_READY;
            pready_d  = 1'b1;
            pslverr_d = addr_err;
            prdata_d  = (!PWRITE && !addr_err) ? regs_q[addr_idx] : '0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (access) begin
          proto_err_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (!access) begin
          state_d     = S_IDLE;
          proto_err_d = 1'b1;
          pready_d    = 1'b0;
          pslverr_d   = 1'b0;
          prdata_d    = '0;
        end else if (cnt_q == 4'd1) begin
          state_d   = S_READY;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = (!write_q && !err_q) ? regs_q[idx_q] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_READY: begin
        if (!access) begin
          proto_err_d = 1'b1;
        end else if (write_q && !err_q) begin
          regs_d[idx_q] = wdata_q;
        end
        state_d   = S_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge apbClk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      proto_err_q <= proto_err_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DW +: DW] = regs_q[g];
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (0, 3 and 2 wait states) checked every
// cycle against a transaction-level register model, plus literal spot checks.
module tb_apb_reg_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam int          ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0]    paddr  [ND];
  logic [DW-1:0]    pwdata [ND];
  logic [DW-1:0]    prdata [ND];
  logic [ND-1:0]    psel, penable, pwrite, pready, pslverr, proto_err;
  logic [NR*DW-1:0] regs_o [ND];

  // Model: register contents, sticky flag and expected bus outputs per instance.
  logic [DW-1:0] mregs [ND][NR];
  logic [ND-1:0] mproto, exp_pready, exp_pslverr;
  logic [DW-1:0] exp_prdata [ND];

  bit check_en = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
                  .WAIT_STATES(0), .RESET_VAL(32'h0)) u_dut0 (
    .apbClk(clk), .rst(rst), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSEL(psel[0]),
    .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .regs_o(regs_o[0]), .proto_err(proto_err[0]));

  apb_reg_slave #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
                  .WAIT_STATES(3), .RESET_VAL(32'h0)) u_dut1 (
    .apbClk(clk), .rst(rst), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSEL(psel[1]),
    .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .regs_o(regs_o[1]), .proto_err(proto_err[1]));

  apb_reg_slave #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
                  .WAIT_STATES(2), .RESET_VAL(32'h0)) u_dut2 (
    .apbClk(clk), .rst(rst), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSEL(psel[2]),
    .PENABLE(penable[2]), .PWRITE(pwrite[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .regs_o(regs_o[2]), .proto_err(proto_err[2]));

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit addr_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= AW'(NR));
  endfunction

  function automatic void chk(input string name, input logic [NR*DW-1:0] act,
                              input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < int'(NR); i++) mregs[d][i] = '0;
      exp_prdata[d] = '0;
    end
    mproto      = '0;
    exp_pready  = '0;
    exp_pslverr = '0;
  endfunction

  always @(negedge clk) begin : cmp
    logic [NR*DW-1:0] flat;
    if (check_en) begin
      for (int d = 0; d < ND; d++) begin
        for (int i = 0; i < int'(NR); i++) flat[i*DW +: DW] = mregs[d][i];
        chk($sformatf("dut%0d PREADY", d),    pready[d],    exp_pready[d]);
        chk($sformatf("dut%0d PSLVERR", d),   pslverr[d],   exp_pslverr[d]);
        chk($sformatf("dut%0d PRDATA", d),    prdata[d],    exp_prdata[d]);
        chk($sformatf("dut%0d proto_err", d), proto_err[d], mproto[d]);
        chk($sformatf("dut%0d regs_o", d),    regs_o[d],    flat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Master holds the access phase for WS+1 cycles; PWDATA is scrambled during
  // the access phase so only the setup-phase value may be committed.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input bit rst_mid,
                      output logic [DW-1:0] rdata, output bit slverr, output int rdy_cycle);
    int n;
    bit bad;
    n = ws_of(d) + 1;
    bad = addr_bad(addr);
    rdata = '0;
    slverr = 1'b0;
    rdy_cycle = 0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    step();
    penable[d] = 1'b1;
    pwdata[d]  = ~data;
    for (int k = 1; k <= n; k++) begin
      exp_pready[d] = (k == n);
      if (k == n) begin
        exp_pslverr[d] = bad;
        exp_prdata[d]  = (!wr && !bad) ? mregs[d][addr[5:2]] : '0;
        rdata  = prdata[d];
        slverr = pslverr[d];
        if (rst_mid) rst = 1'b1;
      end
      if (pready[d] && rdy_cycle == 0) rdy_cycle = k;
      step();
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0; exp_prdata[d] = '0;
    if (rst_mid) begin
      rst = 1'b0;
      model_reset();
    end else if (wr && !bad) begin
      mregs[d][addr[5:2]] = data;
    end
  endtask

  task automatic abort_xfer(input int d, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int n_acc);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr; pwdata[d] = data;
    step();
    penable[d] = 1'b1;
    for (int k = 0; k < n_acc; k++) step();
    psel[d] = 1'b0; penable[d] = 1'b0;
    step();
    mproto[d] = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit se;
    int rc;
    psel = '0; penable = '0; pwrite = '0;
    for (int d = 0; d < ND; d++) begin
      paddr[d] = '0;
      pwdata[d] = '0;
    end
    model_reset();
    rst = 1'b1;
    step();
    check_en = 1'b1;
    step();
    rst = 1'b0;
    chk("reset regs_o dut0", regs_o[0], '0);
    chk("reset proto_err", proto_err, '0);

    // Zero wait states: write then read back.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, rd, se, rc);
    chk("ws0 write ready cycle", rc, 1);
    chk("ws0 write pslverr", se, 0);
    xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, rd, se, rc);
    chk("ws0 read ready cycle", rc, 1);
    chk("ws0 read data", rd, 32'hDEADBEEF);
    chk("ws0 regs_o reg2", regs_o[0][2*DW +: DW], 32'hDEADBEEF);

    // Three wait states.
    xfer(1, 1'b1, 32'h0C, 32'h12345678, 1'b0, rd, se, rc);
    chk("ws3 write ready cycle", rc, 4);
    xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0, rd, se, rc);
    chk("ws3 read data", rd, 32'h12345678);
    chk("ws3 read ready cycle", rc, 4);

    // Bad addresses.
    xfer(0, 1'b1, 32'h40, 32'h55AA55AA, 1'b0, rd, se, rc);
    chk("err write 0x40 pslverr", se, 1);
    xfer(0, 1'b1, 32'h05, 32'h77777777, 1'b0, rd, se, rc);
    chk("err write 0x05 pslverr", se, 1);
    xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, se, rc);
    chk("err read 0x40 pslverr", se, 1);
    chk("err read 0x40 data", rd, 32'h0);
    chk("err regs untouched", regs_o[0], {{(NR-3)*DW{1'b0}}, 32'hDEADBEEF, 64'h0});

    // Back-to-back write/read of the top register.
    xfer(0, 1'b1, 32'h3C, 32'h0BADF00D, 1'b0, rd, se, rc);
    xfer(0, 1'b0, 32'h3C, 32'h0, 1'b0, rd, se, rc);
    chk("b2b read data", rd, 32'h0BADF00D);

    // Abort mid-wait, then a legal write.
    abort_xfer(2, 32'h00, 32'h11111111, 1);
    chk("abort proto_err", proto_err[2], 1);
    chk("abort reg0 unchanged", regs_o[2][DW-1:0], 32'h0);
    xfer(2, 1'b1, 32'h00, 32'hCAFEF00D, 1'b0, rd, se, rc);
    xfer(2, 1'b0, 32'h00, 32'h0, 1'b0, rd, se, rc);
    chk("post-abort read data", rd, 32'hCAFEF00D);
    chk("post-abort ready cycle", rc, 3);

    // Access phase without a setup phase.
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b0; paddr[1] = 32'h0;
    step();
    mproto[1] = 1'b1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    step();
    chk("idle access proto_err", proto_err[1], 1);

    // Reset during the READY cycle of a write.
    xfer(0, 1'b1, 32'h04, 32'hA5A5A5A5, 1'b1, rd, se, rc);
    chk("rst mid reg1", regs_o[0][DW +: DW], 32'h0);
    chk("rst mid pready", pready[0], 0);
    chk("rst mid proto_err", proto_err, '0);
    chk("rst mid reg2 cleared", regs_o[0][2*DW +: DW], 32'h0);

    xfer(0, 1'b1, 32'h04, 32'h600DCAFE, 1'b0, rd, se, rc);
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b0, rd, se, rc);
    chk("post-reset read data", rd, 32'h600DCAFE);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
